oc8051_ibus_arbiter: RTL and testbench
======================================

# oc8051_ibus_arbiter

Two-master Wishbone arbiter for the shared program-memory bus. Master 0 is the instruction-cache refill port; master 1 is the data-side port used for MOVC and program-memory writes. The arbiter grants one master at a time and holds the grant for the master's whole cycle. It preempts a long refill burst at an ack boundary so the data side cannot starve, and it ends cycles that receive no acknowledge by raising an error to the owning master.

## Interface
Parameters:
- MAX_HOLD, 8: acks the owner may receive while the other master waits; the owner loses the bus after the MAX_HOLD-th ack.
- TO_W, 4: timeout counter width. A cycle times out after 2^TO_W−1 = 15 un-acked strobe cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_adr_i  in  16  master-0 address
- m0_stb_i, m0_cyc_i  in  1  master-0 strobe / cycle
- m0_dat_o  out  32  read data to master 0
- m0_ack_o, m0_err_o  out  1  master-0 acknowledge / error
- m1_adr_i  in  16  master-1 address
- m1_dat_i  in  32  master-1 write data
- m1_we_i, m1_stb_i, m1_cyc_i  in  1  master-1 write enable / strobe / cycle
- m1_dat_o  out  32  read data to master 1
- m1_ack_o, m1_err_o  out  1  master-1 acknowledge / error
- s_adr_o  out  16  slave address
- s_dat_o  out  32  slave write data
- s_we_o, s_stb_o, s_cyc_o  out  1  slave write enable / strobe / cycle
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge

## Operation
- **States:**
  - IDLE: no owner.
  - GNT0: master 0 owns the bus.
  - GNT1: master 1 owns the bus.
- **Request.** A master requests when its cyc_i is 1.
- **Grant from IDLE:**
  - Exactly one requester: grant it.
  - Both request: grant the master that was not granted last (round-robin).
  - The `last` register resets to 1, so master 0 wins the first tie.
- **In GNTx:**
  - s_adr_o, s_stb_o and s_cyc_o pass through from the owner. s_cyc_o = owner cyc_i.
  - s_we_o and s_dat_o come from master 1 only in GNT1; otherwise they are 0. Master 0 is read-only.
- **Routing back to masters:**
  - s_dat_i drives both m0_dat_o and m1_dat_o unconditionally.
  - ackx_o = s_ack_i & GNTx. The non-owner never sees ack.
- **Release:**
  - Owner drops cyc_i: go to GNT of the other master if it is requesting, else IDLE.
  - On release, `last` is set to the releasing owner.
- **Hold limit:**
  - hold_cnt counts owner acks while the other master requests. It clears on grant change and whenever the other master is not requesting.
  - An ack that makes hold_cnt reach MAX_HOLD forces a switch to the other master on the next edge.
  - The preempted master keeps stb/cyc asserted. It is re-granted by round-robin after the other master releases.
- **Timeout:**
  - to_cnt increments each cycle in GNTx with owner stb_i=1 and s_ack_i=0.
  - to_cnt clears on ack, on grant change, and when stb_i=0.
  - When to_cnt = all-ones: pulse errx_o for 1 cycle (combinational with the terminal count), go to IDLE, and set `last` to the owner.
  - A master that receives err must drop cyc_i; re-requesting is allowed.
- **Simultaneous events:**
  - Ack and timeout terminal in the same cycle: ack wins and no err is raised.
  - Owner release and hold-limit switch in the same cycle: treat as a normal release.
- **Mid-operation reset:** rst forces IDLE immediately with all outputs low. Any in-flight cycle is abandoned with no ack and no err.

## Timing
- **Reset values:** state=IDLE, last=1, hold_cnt=0, to_cnt=0. All s_* outputs, ack and err are 0; m0_dat_o and m1_dat_o follow s_dat_i.
- **Grant latency:** a request at cycle N (sampled at edge N+1) gives s_cyc_o/s_stb_o asserted from cycle N+1. There is no combinational request-to-bus path from IDLE.
- **Back-to-back ownership:** handover with no idle cycle. Release seen at N gives the new owner on the bus at N+1.
- **Ack path:** combinational, zero latency, from s_ack_i to m*_ack_o. A 1-cycle slave ack completes one beat per clock.
- **Burst:** four consecutive icache refill beats with ack every cycle finish in 4 cycles when unpreempted.
- **Bus idle:** s_stb_o never asserts in IDLE.

## Test plan
- **Single master:** m0 cyc/stb at cycle 0 with adr 0x0104 and s_ack_i at cycles 1–4 → s_cyc_o high for cycles 1–4; m0_ack_o pulses 4×; m1_ack_o stays 0.
- **Tie from reset:** both cyc at cycle 0 → GNT0 first. After m0 releases, m1 is granted with no gap. A second tie after both release → GNT0, since `last`=1.
- **Hold limit:** m0 bursts continuously with ack every cycle while m1 requests from cycle 0 → after the 8th m0 ack the bus switches to m1; m0 stb stays high with m0_ack_o=0 until m1 releases.
- **Timeout:** m1 write with adr 0x2000, dat 0xA5A5A5A5, we=1 and no ack → m1_err_o pulses exactly at the 15th strobe cycle, the arbiter returns to IDLE, and m1_ack_o stays 0.
- **Ack/timeout collision:** ack arrives exactly at the terminal count → ack_o=1, err_o=0, and the owner keeps the bus.
- **Reset mid-burst:** rst at beat 2 of an m0 burst → all s_* outputs 0 immediately. After rst deassert with m1 requesting, m1 is granted.

Source files
------------

// File: rtl/oc8051_ibus_arbiter_if.sv
// Program-memory bus bundle: both master ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface oc8051_ibus_arbiter_if;
    logic [15:0] m0_adr_i;
    logic        m0_stb_i;
    logic        m0_cyc_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic        m0_err_o;

    logic [15:0] m1_adr_i;
    logic [31:0] m1_dat_i;
    logic        m1_we_i;
    logic        m1_stb_i;
    logic        m1_cyc_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic        m1_err_o;

    logic [15:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    modport slave (
        input  m0_adr_i, m0_stb_i, m0_cyc_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_adr_i, m0_stb_i, m0_cyc_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/oc8051_ibus_arbiter.sv
// Two-master Wishbone arbiter for program memory: round-robin grant, hold-limit
// preemption at ack boundaries, and no-ack timeout that errors the owner.
module oc8051_ibus_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int TO_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    oc8051_ibus_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(MAX_HOLD - 1);
    // The strobe cycle seen with this count is the one that brings to_cnt to all-ones.
    localparam logic [TO_W-1:0]   TO_TERM   = {{(TO_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic own0, own1, own_cyc, own_stb, oth_req, own_ack, timeout, hold_hit;
    state_e other;

    always_comb begin
        own0     = (state_q == GNT0);
        own1     = (state_q == GNT1);
        own_cyc  = (own0 & bus.m0_cyc_i) | (own1 & bus.m1_cyc_i);
        own_stb  = (own0 & bus.m0_stb_i) | (own1 & bus.m1_stb_i);
        oth_req  = (own0 & bus.m1_cyc_i) | (own1 & bus.m0_cyc_i);
        own_ack  = bus.s_ack_i & (own0 | own1);
        other    = own0 ? GNT1 : GNT0;
        // Ack beats the terminal count, so a late ack never produces an err.
        timeout  = own_stb & own_cyc & ~bus.s_ack_i & (to_cnt_q == TO_TERM);
        hold_hit = own_ack & oth_req & (hold_cnt_q == HOLD_TERM);
    end

    assign bus.s_cyc_o  = own_cyc;
    assign bus.s_stb_o  = own_stb;
    assign bus.s_adr_o  = own0 ? bus.m0_adr_i : (own1 ? bus.m1_adr_i : 16'h0000);
    assign bus.s_we_o   = own1 & bus.m1_we_i;
    assign bus.s_dat_o  = own1 ? bus.m1_dat_i : 32'h0000_0000;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.m0_ack_o = bus.s_ack_i & own0;
    assign bus.m1_ack_o = bus.s_ack_i & own1;
    assign bus.m0_err_o = timeout & own0;
    assign bus.m1_err_o = timeout & own1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (bus.m0_cyc_i) begin
                    state_d = GNT0;
                end else if (bus.m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                // A release in the same cycle as a hold-limit hit is an ordinary release.
                if (!own_cyc) begin
                    last_d  = own1;
                    state_d = oth_req ? other : IDLE;
                end else if (timeout) begin
                    last_d  = own1;
                    state_d = IDLE;
                end else if (hold_hit) begin
                    state_d = other;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_d != state_q) || !oth_req) begin
            hold_cnt_d = '0;
        end else if (own_ack) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end

        to_cnt_d = to_cnt_q + TO_W'(1);
        if ((state_d != state_q) || !own_stb || bus.s_ack_i) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end
endmodule

// File: tb/tb_oc8051_ibus_arbiter.sv
// Directed bench for oc8051_ibus_arbiter: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_oc8051_ibus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    oc8051_ibus_arbiter_if bus ();

    oc8051_ibus_arbiter #(.MAX_HOLD(8), .TO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_adr_i = 16'h0; bus.m0_stb_i = 1'b0; bus.m0_cyc_i = 1'b0;
        bus.m1_adr_i = 16'h0; bus.m1_dat_i = 32'h0; bus.m1_we_i = 1'b0;
        bus.m1_stb_i = 1'b0;  bus.m1_cyc_i = 1'b0;
        bus.s_ack_i  = 1'b0;  bus.s_dat_i  = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0104;
        bus.s_ack_i  = 1'b1; bus.s_dat_i  = 32'h1234_5678;
        step();
        @(negedge clk);
        n_cmp++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o});
        end
        n_cmp++;
        if ({bus.s_adr_o, bus.s_dat_o} !== 48'h0) begin
            n_err++; $display("FAIL reset_adr_dat: got %h want 0", {bus.s_adr_o, bus.s_dat_o});
        end
        n_cmp++;
        if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ack_err: got %b want 0000",
                              {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o});
        end
        n_cmp++;
        if (bus.m0_dat_o !== 32'h1234_5678 || bus.m1_dat_o !== 32'h1234_5678) begin
            n_err++; $display("FAIL reset_rdata: got %h/%h want 12345678", bus.m0_dat_o, bus.m1_dat_o);
        end
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_master();
        int acks = 0;
        for (int c = 0; c <= 6; c++) begin
            bus.m0_cyc_i = (c <= 4); bus.m0_stb_i = (c <= 4);
            bus.m0_adr_i = 16'h0104;
            bus.s_ack_i  = (c >= 1 && c <= 4);
            bus.s_dat_i  = 32'hC0DE_0000 + 32'(c);
            @(negedge clk);
            n_cmp++;
            if (bus.s_cyc_o !== (c >= 1 && c <= 4) || bus.s_stb_o !== (c >= 1 && c <= 4)) begin
                n_err++; $display("FAIL single_cyc c%0d: got %b%b want %b", c, bus.s_cyc_o, bus.s_stb_o,
                                  (c >= 1 && c <= 4));
            end
            n_cmp++;
            if (bus.m0_ack_o !== (c >= 1 && c <= 4) || bus.m1_ack_o !== 1'b0) begin
                n_err++; $display("FAIL single_ack c%0d: got m0=%b m1=%b", c, bus.m0_ack_o, bus.m1_ack_o);
            end
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (bus.s_adr_o !== 16'h0104 || bus.s_we_o !== 1'b0 || bus.m0_dat_o !== 32'hC0DE_0000 + 32'(c)) begin
                    n_err++; $display("FAIL single_adr c%0d: got adr=%h we=%b dat=%h", c, bus.s_adr_o,
                                      bus.s_we_o, bus.m0_dat_o);
                end
            end
            if (bus.m0_ack_o === 1'b1) acks++;
            step();
        end
        n_cmp++;
        if (acks !== 4) begin
            n_err++; $display("FAIL single_ack_count: got %0d want 4", acks);
        end
        idle_inputs();
    endtask

    task automatic test_tie();
        logic [7:0] m0c  = 8'b0110_0011;
        logic [7:0] m1c  = 8'b0110_1111;
        logic [7:0] ack  = 8'b0000_1010;
        logic [7:0] ecyc = 8'b0100_1010;
        logic [7:0] ea0  = 8'b0000_0010;
        logic [7:0] ea1  = 8'b0000_1000;
        do_reset();
        bus.m0_adr_i = 16'h0104; bus.m1_adr_i = 16'h3000;
        for (int c = 0; c < 8; c++) begin
            bus.m0_cyc_i = m0c[c]; bus.m0_stb_i = m0c[c];
            bus.m1_cyc_i = m1c[c]; bus.m1_stb_i = m1c[c];
            bus.s_ack_i  = ack[c];
            @(negedge clk);
            n_cmp++;
            if (bus.s_cyc_o !== ecyc[c]) begin
                n_err++; $display("FAIL tie_cyc c%0d: got %b want %b", c, bus.s_cyc_o, ecyc[c]);
            end
            n_cmp++;
            if (bus.m0_ack_o !== ea0[c] || bus.m1_ack_o !== ea1[c]) begin
                n_err++; $display("FAIL tie_ack c%0d: got %b%b want %b%b", c, bus.m0_ack_o, bus.m1_ack_o,
                                  ea0[c], ea1[c]);
            end
            if (ecyc[c]) begin
                n_cmp++;
                if (bus.s_adr_o !== ((c == 3) ? 16'h3000 : 16'h0104)) begin
                    n_err++; $display("FAIL tie_owner c%0d: got adr %h", c, bus.s_adr_o);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_hold_limit();
        int acks = 0;
        do_reset();
        bus.m0_adr_i = 16'h0200; bus.m1_adr_i = 16'h4000;
        for (int c = 0; c <= 12; c++) begin
            bus.m0_cyc_i = (c <= 11); bus.m0_stb_i = (c <= 11);
            bus.m1_cyc_i = (c <= 9);  bus.m1_stb_i = (c <= 9);
            bus.s_ack_i  = (c >= 1 && c <= 9) || (c == 11);
            @(negedge clk);
            n_cmp++;
            if (bus.m0_ack_o !== ((c >= 1 && c <= 8) || c == 11)) begin
                n_err++; $display("FAIL hold_m0_ack c%0d: got %b", c, bus.m0_ack_o);
            end
            n_cmp++;
            if (bus.m1_ack_o !== (c == 9)) begin
                n_err++; $display("FAIL hold_m1_ack c%0d: got %b", c, bus.m1_ack_o);
            end
            if (c == 9 || c == 11) begin
                n_cmp++;
                if (bus.s_adr_o !== ((c == 9) ? 16'h4000 : 16'h0200) || bus.s_cyc_o !== 1'b1) begin
                    n_err++; $display("FAIL hold_owner c%0d: got adr %h cyc %b", c, bus.s_adr_o, bus.s_cyc_o);
                end
            end
            if (c <= 9 && bus.m0_ack_o === 1'b1) acks++;
            step();
        end
        n_cmp++;
        if (acks !== 8) begin
            n_err++; $display("FAIL hold_ack_count: got %0d want 8", acks);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        bus.m1_adr_i = 16'h2000; bus.m1_dat_i = 32'hA5A5_A5A5; bus.m1_we_i = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            bus.m1_cyc_i = (c <= 16); bus.m1_stb_i = (c <= 16);
            @(negedge clk);
            n_cmp++;
            if (bus.m1_err_o !== (c == 15) || bus.m0_err_o !== 1'b0) begin
                n_err++; $display("FAIL to_err c%0d: got m1=%b m0=%b", c, bus.m1_err_o, bus.m0_err_o);
            end
            n_cmp++;
            if (bus.s_cyc_o !== (c >= 1 && c <= 15) || bus.m1_ack_o !== 1'b0) begin
                n_err++; $display("FAIL to_cyc c%0d: got cyc=%b ack=%b", c, bus.s_cyc_o, bus.m1_ack_o);
            end
            if (c == 1) begin
                n_cmp++;
                if (bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'hA5A5_A5A5 || bus.s_adr_o !== 16'h2000) begin
                    n_err++; $display("FAIL to_write: got we=%b dat=%h adr=%h", bus.s_we_o, bus.s_dat_o, bus.s_adr_o);
                end
            end
            if (c == 16) begin
                n_cmp++;
                if (bus.s_stb_o !== 1'b0 || bus.s_we_o !== 1'b0) begin
                    n_err++; $display("FAIL to_idle: got stb=%b we=%b want 0", bus.s_stb_o, bus.s_we_o);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_ack_timeout_collision();
        bus.m0_adr_i = 16'h0300;
        for (int c = 0; c <= 18; c++) begin
            bus.m0_cyc_i = (c <= 16); bus.m0_stb_i = (c <= 16);
            bus.s_ack_i  = (c == 15);
            @(negedge clk);
            n_cmp++;
            if (bus.m0_err_o !== 1'b0) begin
                n_err++; $display("FAIL coll_err c%0d: got %b want 0", c, bus.m0_err_o);
            end
            n_cmp++;
            if (bus.s_cyc_o !== (c >= 1 && c <= 16) || bus.m0_ack_o !== (c == 15)) begin
                n_err++; $display("FAIL coll_bus c%0d: got cyc=%b ack=%b", c, bus.s_cyc_o, bus.m0_ack_o);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        bus.m0_adr_i = 16'h0400; bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
        step();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.m0_ack_o !== 1'b1 || bus.s_adr_o !== 16'h0400) begin
            n_err++; $display("FAIL rstmid_beat1: got ack=%b adr=%h", bus.m0_ack_o, bus.s_adr_o);
        end
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o, bus.m0_err_o} !== 4'b0000 || bus.s_adr_o !== 16'h0) begin
            n_err++; $display("FAIL rstmid_abort: got cyc=%b stb=%b ack=%b err=%b adr=%h", bus.s_cyc_o,
                              bus.s_stb_o, bus.m0_ack_o, bus.m0_err_o, bus.s_adr_o);
        end
        step();
        idle_inputs();
        bus.m1_adr_i = 16'h5000; bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.s_cyc_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_held: got cyc=%b want 0", bus.s_cyc_o);
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 16'h5000) begin
            n_err++; $display("FAIL rstmid_m1_grant: got cyc=%b adr=%h want 1/5000", bus.s_cyc_o, bus.s_adr_o);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        step();
        test_reset();
        test_single_master();
        test_tie();
        test_hold_limit();
        test_timeout();
        test_ack_timeout_collision();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
